control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have these ports, one clock domain, all outputs combinational from state register plus IROut; one clock, reset synchronous active-high:
 Clock  in  1  rising-edge clock
 Reset  in  1  synchronous active-high reset
 IROut  in  16  instruction register contents; opcode [15:12], Rd [11:10], Rs1 [9:8], Rs2 [7:6], imm8 [7:0]
 ALU_Flags  in  4  {Z,C,N,O}, bit 3 = Z
 RF_OutASel, RF_OutBSel, RF_FunSel  out  3 each
 RF_RegSel, RF_ScrSel  out  4 each  one-hot active-high, bit 3 = R1 / S1
 ALU_FunSel  out  5;  ALU_WF  out  1
 ARF_OutCSel, ARF_OutDSel  out  2 each  00 PC, 01 SP, 10 AR
 ARF_FunSel  out  3;  ARF_RegSel  out  3  one-hot active-high {PC,AR,SP}
 IR_LH, IR_Write, Mem_WR, Mem_CS, MuxCSel  out  1 each;  MuxASel, MuxBSel  out  2 each
 SeqT  out  2  current state code;  Halted  out  1
REQ-002 Encodings SHALL be: RF/ARF FunSel 3'b001 increment, 3'b010 load; ALU_FunSel 5'b10000 pass A, 5'b10100 A+B, 5'b10110 A-B, 5'b10111 AND, 5'b11000 OR; Mem_CS=0 enables, Mem_WR=0 read, 1 write.

Function
REQ-003 States SHALL be FETCH_L (SeqT=0), FETCH_H (1), EXEC (2), HALT (3); FETCH_L->FETCH_H->EXEC->FETCH_L unconditionally, except EXEC with opcode 0xF -> HALT; HALT is absorbing until Reset.
REQ-004 Idle output set (used in every state/opcode not listed): all RegSel/ScrSel 0, IR_Write 0, ALU_WF 0, Mem_CS 1, Mem_WR 0, all selects and FunSel 0.
REQ-005 FETCH_L SHALL drive ARF_OutDSel=00, Mem_CS=0, Mem_WR=0, IR_Write=1, IR_LH=0, ARF_RegSel=100, ARF_FunSel=001 (PC+1).
REQ-006 FETCH_H SHALL match FETCH_L except IR_LH=1.
REQ-007 EXEC ADD/SUB/AND/OR (0x1-0x4): RF_OutASel=Rs1, RF_OutBSel=Rs2, ALU_FunSel per REQ-002, ALU_WF=1, MuxASel=00, RF_FunSel=010, RF_RegSel=one-hot Rd.
REQ-008 EXEC MOVI (0x5): MuxASel=11, RF_FunSel=010, RF_RegSel=Rd; Rd receives zero-extended imm8.
REQ-009 EXEC LD (0x6): ARF_OutDSel=10, Mem_CS=0, Mem_WR=0, MuxASel=10, RF_FunSel=010, RF_RegSel=Rd.
REQ-010 EXEC ST (0x7): RF_OutASel=Rd, ALU_FunSel=10000, MuxCSel=0, ARF_OutDSel=10, Mem_CS=0, Mem_WR=1.
REQ-011 EXEC BRA (0x9), and BRZ (0x8) only when ALU_Flags[3]=1: MuxBSel=11, ARF_FunSel=010, ARF_RegSel=100; BRZ with Z=0 SHALL use idle set.
REQ-012 EXEC NOP (0x0) SHALL use idle set; every instruction except HLT takes exactly 3 cycles.
REQ-013 Halted SHALL be 1 only in HALT; HALT outputs idle set.
REQ-014 IROut SHALL be sampled only in EXEC; changes in other states SHALL not affect outputs.

Reset
REQ-015 Reset=1 at a rising edge SHALL force FETCH_L next cycle from any state, including mid-instruction and HALT.
REQ-016 While Reset=1, all outputs SHALL be the idle set, SeqT=0, Halted=0; no register or memory write occurs.

Configuration
REQ-017 With SEQ_ILLEGAL_TRAP_EN defined, opcodes 0xA-0xE in EXEC SHALL go to HALT and an extra output Illegal (1 bit) SHALL be 1 in HALT entered that way, cleared by Reset; without it, 0xA-0xE SHALL execute as NOP, HALT is reached only by 0xF, and port Illegal SHALL not exist.

Verification
REQ-018 Reset 2 cycles, release -> SeqT 0,1,2,0 repeating; IR_Write=1,IR_LH=0 then 1; PC incremented twice per instruction.
REQ-019 IROut=0x1640 (ADD R2,R3,R2) in EXEC -> RF_OutASel=2, RF_OutBSel=1, ALU_FunSel=10100, ALU_WF=1, RF_RegSel=0100.
REQ-020 IROut=0x8012 with Z=0 -> idle set; with Z=1 -> MuxBSel=11, ARF_FunSel=010, ARF_RegSel=100.
REQ-021 IROut=0x7C00 (ST R4) -> Mem_WR=1, Mem_CS=0, ARF_OutDSel=10, RF_OutASel=3.
REQ-022 IROut=0xF000 -> HALT, Halted=1 held 10 cycles; Reset -> FETCH_L, Halted=0.
REQ-023 Reset asserted in FETCH_H -> idle set that cycle, FETCH_L next; IROut=0xA000 -> HALT+Illegal=1 (trap build) or NOP (default build).

Source files
------------

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath it steers.
// The master side (sequencer) reads the instruction register and ALU flags
// and drives every datapath control line; the slave side is the datapath.
interface control_sequencer_if;
    logic [15:0] IROut;
    logic [3:0]  ALU_Flags;
    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [2:0]  RF_FunSel;
    logic [3:0]  RF_RegSel;
    logic [3:0]  RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic [2:0]  ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH;
    logic        IR_Write;
    logic        Mem_WR;
    logic        Mem_CS;
    logic        MuxCSel;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic [1:0]  SeqT;
    logic        Halted;

    modport master (
        input  IROut, ALU_Flags,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
               ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxCSel,
               MuxASel, MuxBSel, SeqT, Halted
    );

    modport slave (
        output IROut, ALU_Flags,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
               ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxCSel,
               MuxASel, MuxBSel, SeqT, Halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Three-phase instruction sequencer: fetch low byte, fetch high byte, execute.
// Control outputs are decoded combinationally from the state register and
// IROut, and forced to the idle set while Reset is high.
// Optional build macro SEQ_ILLEGAL_TRAP_EN: opcodes 0xA-0xE halt the machine
// and raise the Illegal output; without it they behave as NOP.
module control_sequencer (
    input  logic                 Clock,
    input  logic                 Reset,
    control_sequencer_if.master  bus
`ifdef SEQ_ILLEGAL_TRAP_EN
    ,
    output logic                 Illegal
`endif
);
    typedef enum logic [1:0] {
        FETCH_L = 2'd0,
        FETCH_H = 2'd1,
        EXEC    = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t state_q;

    logic [3:0] opcode;
    logic [1:0] rd, rs1, rs2;
    logic [3:0] rd_onehot;
    logic       zflag;

    assign opcode    = bus.IROut[15:12];
    assign rd        = bus.IROut[11:10];
    assign rs1       = bus.IROut[9:8];
    assign rs2       = bus.IROut[7:6];
    assign zflag     = bus.ALU_Flags[3];
    // Register file select is one-hot with R1 on bit 3, so Rd=0 maps to bit 3.
    assign rd_onehot = 4'b1000 >> rd;

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic illegal_q;
`endif

    // Sequencer state: fixed three-phase cycle, HALT absorbs until Reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= FETCH_L;
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                FETCH_L: state_q <= FETCH_H;
                FETCH_H: state_q <= EXEC;
                EXEC: begin
                    if (opcode == 4'hF) begin
                        state_q <= HALT;
`ifdef SEQ_ILLEGAL_TRAP_EN
                    end else if (opcode >= 4'hA) begin
                        state_q   <= HALT;
                        illegal_q <= 1'b1;
`endif
                    end else begin
                        state_q <= FETCH_L;
                    end
                end
                default: state_q <= HALT;
            endcase
        end
    end

    // Control decode: start from the idle set, then overlay per state/opcode.
    always_comb begin
        bus.RF_OutASel  = 3'b000;
        bus.RF_OutBSel  = 3'b000;
        bus.RF_FunSel   = 3'b000;
        bus.RF_RegSel   = 4'b0000;
        bus.RF_ScrSel   = 4'b0000;
        bus.ALU_FunSel  = 5'b00000;
        bus.ALU_WF      = 1'b0;
        bus.ARF_OutCSel = 2'b00;
        bus.ARF_OutDSel = 2'b00;
        bus.ARF_FunSel  = 3'b000;
        bus.ARF_RegSel  = 3'b000;
        bus.IR_LH       = 1'b0;
        bus.IR_Write    = 1'b0;
        bus.Mem_WR      = 1'b0;
        bus.Mem_CS      = 1'b1;
        bus.MuxCSel     = 1'b0;
        bus.MuxASel     = 2'b00;
        bus.MuxBSel     = 2'b00;
        bus.SeqT        = 2'b00;
        bus.Halted      = 1'b0;
        if (!Reset) begin
            bus.SeqT   = state_q;
            bus.Halted = (state_q == HALT);
            case (state_q)
                FETCH_L, FETCH_H: begin
                    // Read M[PC] into one IR half and bump PC.
                    bus.ARF_OutDSel = 2'b00;
                    bus.Mem_CS      = 1'b0;
                    bus.Mem_WR      = 1'b0;
                    bus.IR_Write    = 1'b1;
                    bus.IR_LH       = (state_q == FETCH_H);
                    bus.ARF_RegSel  = 3'b100;
                    bus.ARF_FunSel  = 3'b001;
                end
                EXEC: begin
                    case (opcode)
                        4'h1, 4'h2, 4'h3, 4'h4: begin
                            bus.RF_OutASel = {1'b0, rs1};
                            bus.RF_OutBSel = {1'b0, rs2};
                            case (opcode)
                                4'h1:    bus.ALU_FunSel = 5'b10100;
                                4'h2:    bus.ALU_FunSel = 5'b10110;
                                4'h3:    bus.ALU_FunSel = 5'b10111;
                                default: bus.ALU_FunSel = 5'b11000;
                            endcase
                            bus.ALU_WF    = 1'b1;
                            bus.MuxASel   = 2'b00;
                            bus.RF_FunSel = 3'b010;
                            bus.RF_RegSel = rd_onehot;
                        end
                        4'h5: begin
                            // MuxA input 11 carries the zero-extended imm8.
                            bus.MuxASel   = 2'b11;
                            bus.RF_FunSel = 3'b010;
                            bus.RF_RegSel = rd_onehot;
                        end
                        4'h6: begin
                            bus.ARF_OutDSel = 2'b10;
                            bus.Mem_CS      = 1'b0;
                            bus.Mem_WR      = 1'b0;
                            bus.MuxASel     = 2'b10;
                            bus.RF_FunSel   = 3'b010;
                            bus.RF_RegSel   = rd_onehot;
                        end
                        4'h7: begin
                            bus.RF_OutASel  = {1'b0, rd};
                            bus.ALU_FunSel  = 5'b10000;
                            bus.MuxCSel     = 1'b0;
                            bus.ARF_OutDSel = 2'b10;
                            bus.Mem_CS      = 1'b0;
                            bus.Mem_WR      = 1'b1;
                        end
                        4'h8, 4'h9: begin
                            // BRZ only branches when Z is set; BRA always does.
                            if (opcode == 4'h9 || zflag) begin
                                bus.MuxBSel    = 2'b11;
                                bus.ARF_FunSel = 3'b010;
                                bus.ARF_RegSel = 3'b100;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    // Illegal flag is only visible once the machine has trapped into HALT.
    always_comb begin
        Illegal = !Reset && illegal_q && (state_q == HALT);
    end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a table of execute-phase vectors
// plus hand-written sequences for reset, halt and illegal-opcode behaviour.
module tb_control_sequencer;
    logic Clock = 1'b0;
    logic Reset;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic Illegal;
`endif

    control_sequencer_if bus ();

    control_sequencer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
`ifdef SEQ_ILLEGAL_TRAP_EN
        ,
        .Illegal (Illegal)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0] outa;
        logic [2:0] outb;
        logic [2:0] rffun;
        logic [3:0] regsel;
        logic [3:0] scrsel;
        logic [4:0] alufun;
        logic       wf;
        logic [1:0] outc;
        logic [1:0] outd;
        logic [2:0] arffun;
        logic [2:0] arfreg;
        logic       irlh;
        logic       irw;
        logic       memwr;
        logic       memcs;
        logic       muxc;
        logic [1:0] muxa;
        logic [1:0] muxb;
        logic [1:0] seqt;
        logic       halted;
    } outs_t;

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic [3:0]  flags;
        outs_t       exp;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    outs_t IDLE, EX_IDLE, FL, FH, HLT_EXP;
    vec_t  tbl[12];

    function automatic outs_t sample();
        outs_t o;
        o.outa   = bus.RF_OutASel;
        o.outb   = bus.RF_OutBSel;
        o.rffun  = bus.RF_FunSel;
        o.regsel = bus.RF_RegSel;
        o.scrsel = bus.RF_ScrSel;
        o.alufun = bus.ALU_FunSel;
        o.wf     = bus.ALU_WF;
        o.outc   = bus.ARF_OutCSel;
        o.outd   = bus.ARF_OutDSel;
        o.arffun = bus.ARF_FunSel;
        o.arfreg = bus.ARF_RegSel;
        o.irlh   = bus.IR_LH;
        o.irw    = bus.IR_Write;
        o.memwr  = bus.Mem_WR;
        o.memcs  = bus.Mem_CS;
        o.muxc   = bus.MuxCSel;
        o.muxa   = bus.MuxASel;
        o.muxb   = bus.MuxBSel;
        o.seqt   = bus.SeqT;
        o.halted = bus.Halted;
        return o;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (seqt %0d/%0d)", name, act, exp, act.seqt, exp.seqt);
        end
    endtask

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    initial begin
        IDLE = '0;
        IDLE.memcs = 1'b1;
        EX_IDLE = IDLE;
        EX_IDLE.seqt = 2'd2;
        FL = IDLE;
        FL.memcs = 1'b0;
        FL.irw = 1'b1;
        FL.arfreg = 3'b100;
        FL.arffun = 3'b001;
        FH = FL;
        FH.irlh = 1'b1;
        FH.seqt = 2'd1;
        HLT_EXP = IDLE;
        HLT_EXP.seqt = 2'd3;
        HLT_EXP.halted = 1'b1;

        // ADD R2,R3,R2 : Rd=1 Rs1=2 Rs2=1
        tbl[0].name = "add"; tbl[0].ir = 16'h1640; tbl[0].flags = 4'h0;
        tbl[0].exp = EX_IDLE; tbl[0].exp.outa = 3'd2; tbl[0].exp.outb = 3'd1;
        tbl[0].exp.alufun = 5'b10100; tbl[0].exp.wf = 1'b1;
        tbl[0].exp.rffun = 3'b010; tbl[0].exp.regsel = 4'b0100;
        // SUB : Rd=3 Rs1=1 Rs2=2
        tbl[1].name = "sub"; tbl[1].ir = 16'h2D80; tbl[1].flags = 4'hF;
        tbl[1].exp = EX_IDLE; tbl[1].exp.outa = 3'd1; tbl[1].exp.outb = 3'd2;
        tbl[1].exp.alufun = 5'b10110; tbl[1].exp.wf = 1'b1;
        tbl[1].exp.rffun = 3'b010; tbl[1].exp.regsel = 4'b0001;
        // AND : Rd=0 Rs1=2 Rs2=0
        tbl[2].name = "and"; tbl[2].ir = 16'h3200; tbl[2].flags = 4'h0;
        tbl[2].exp = EX_IDLE; tbl[2].exp.outa = 3'd2; tbl[2].exp.outb = 3'd0;
        tbl[2].exp.alufun = 5'b10111; tbl[2].exp.wf = 1'b1;
        tbl[2].exp.rffun = 3'b010; tbl[2].exp.regsel = 4'b1000;
        // OR : Rd=1 Rs1=3 Rs2=3
        tbl[3].name = "or"; tbl[3].ir = 16'h47C0; tbl[3].flags = 4'h0;
        tbl[3].exp = EX_IDLE; tbl[3].exp.outa = 3'd3; tbl[3].exp.outb = 3'd3;
        tbl[3].exp.alufun = 5'b11000; tbl[3].exp.wf = 1'b1;
        tbl[3].exp.rffun = 3'b010; tbl[3].exp.regsel = 4'b0100;
        // MOVI : Rd=2
        tbl[4].name = "movi"; tbl[4].ir = 16'h5AFF; tbl[4].flags = 4'h0;
        tbl[4].exp = EX_IDLE; tbl[4].exp.muxa = 2'b11;
        tbl[4].exp.rffun = 3'b010; tbl[4].exp.regsel = 4'b0010;
        // LD : Rd=1
        tbl[5].name = "ld"; tbl[5].ir = 16'h6400; tbl[5].flags = 4'h0;
        tbl[5].exp = EX_IDLE; tbl[5].exp.outd = 2'b10; tbl[5].exp.memcs = 1'b0;
        tbl[5].exp.muxa = 2'b10; tbl[5].exp.rffun = 3'b010; tbl[5].exp.regsel = 4'b0100;
        // ST R4 : Rd=3
        tbl[6].name = "st"; tbl[6].ir = 16'h7C00; tbl[6].flags = 4'h0;
        tbl[6].exp = EX_IDLE; tbl[6].exp.outa = 3'd3; tbl[6].exp.alufun = 5'b10000;
        tbl[6].exp.outd = 2'b10; tbl[6].exp.memcs = 1'b0; tbl[6].exp.memwr = 1'b1;
        // BRZ with Z=0 but other flags set -> idle
        tbl[7].name = "brz_nz"; tbl[7].ir = 16'h8012; tbl[7].flags = 4'b0111;
        tbl[7].exp = EX_IDLE;
        // BRZ with Z=1
        tbl[8].name = "brz_z"; tbl[8].ir = 16'h8012; tbl[8].flags = 4'b1000;
        tbl[8].exp = EX_IDLE; tbl[8].exp.muxb = 2'b11;
        tbl[8].exp.arffun = 3'b010; tbl[8].exp.arfreg = 3'b100;
        // BRA with Z=0
        tbl[9].name = "bra"; tbl[9].ir = 16'h9034; tbl[9].flags = 4'h0;
        tbl[9].exp = tbl[8].exp;
        // NOP with junk low bits
        tbl[10].name = "nop"; tbl[10].ir = 16'h0FFF; tbl[10].flags = 4'hF;
        tbl[10].exp = EX_IDLE;
        // ADD again with Rd=0 after mixed history
        tbl[11].name = "add_r1"; tbl[11].ir = 16'h10C0; tbl[11].flags = 4'h0;
        tbl[11].exp = EX_IDLE; tbl[11].exp.outa = 3'd0; tbl[11].exp.outb = 3'd3;
        tbl[11].exp.alufun = 5'b10100; tbl[11].exp.wf = 1'b1;
        tbl[11].exp.rffun = 3'b010; tbl[11].exp.regsel = 4'b1000;

        // Two reset cycles, then release.
        Reset = 1'b1;
        bus.IROut = 16'h1640;
        bus.ALU_Flags = 4'h0;
        step();
        check("reset_idle", IDLE);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("fetch_l0", FL);
        step();
        check("fetch_h0", FH);

        // Table: each instruction takes EXEC, FETCH_L, FETCH_H.
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            bus.IROut = tbl[i].ir;
            bus.ALU_Flags = tbl[i].flags;
            #1;
            check({tbl[i].name, "_exec"}, tbl[i].exp);
            step();
            check({tbl[i].name, "_fl"}, FL);
            step();
            check({tbl[i].name, "_fh"}, FH);
        end

        // Reset raised during FETCH_H: idle immediately, FETCH_L next.
        Reset = 1'b1;
        #1;
        check("rst_in_fh", IDLE);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("rst_fh_fl", FL);
        step();
        check("rst_fh_fh", FH);

        // Reset raised during a store's EXEC: no memory write that cycle.
        @(negedge Clock);
        bus.IROut = 16'h7C00;
        Reset = 1'b1;
        #1;
        check("rst_in_st", IDLE);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("rst_st_fl", FL);
        step();
        check("rst_st_fh", FH);

        // HLT: idle in EXEC, then absorbing HALT regardless of IROut.
        @(negedge Clock);
        bus.IROut = 16'hF000;
        #1;
        check("hlt_exec", EX_IDLE);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            bus.IROut = (i % 2 == 0) ? 16'h1640 : 16'h9000;
            #1;
            check("halt_hold", HLT_EXP);
        end
        Reset = 1'b1;
        #1;
        check("halt_rst", IDLE);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("halt_rst_fl", FL);
        step();
        check("halt_rst_fh", FH);

        // Opcode 0xA.
        @(negedge Clock);
        bus.IROut = 16'hA000;
        #1;
        check("op_a_exec", EX_IDLE);
        step();
`ifdef SEQ_ILLEGAL_TRAP_EN
        check("op_a_halt", HLT_EXP);
        n_vec++;
        if (Illegal !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_flag: got %b want 1", Illegal);
        end
`else
        check("op_a_nop_fl", FL);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
